// File: rtl/traffic_demand_if.sv
// traffic_demand_if
//   Groups the per-road signals exchanged between the vehicle-loop front end
//   and its neighbours (sensor side, light controller side).
//   Optional feature macro: DEMAND_OVERFLOW_EN adds the sticky ovf[3:0] flags.
// Signals
//   raw1..raw4    1        raw loop-detector level per road (asynchronous)
//   Road1..Road4  4        light code per road: 0=red, 1=green, 2=yellow
//   c1..c4        1        registered demand per road (queue non-zero)
//   q1..q4        QUEUE_W  queued vehicle count per road
//   ovf           4        sticky overflow flags, bit n-1 = road n (macro only)
// Modports
//   master : stimulus / controller side (drives raw and Road, observes c, q)
//   slave  : traffic_demand_detector side
interface traffic_demand_if #(
  parameter int QUEUE_W = 4
);
  logic               raw1, raw2, raw3, raw4;
  logic [3:0]         Road1, Road2, Road3, Road4;
  logic               c1, c2, c3, c4;
  logic [QUEUE_W-1:0] q1, q2, q3, q4;
`ifdef DEMAND_OVERFLOW_EN
  logic [3:0]         ovf;
`endif

  modport master (
    output raw1, raw2, raw3, raw4,
    output Road1, Road2, Road3, Road4,
    input  c1, c2, c3, c4,
    input  q1, q2, q3, q4
`ifdef DEMAND_OVERFLOW_EN
    ,
    input  ovf
`endif
  );

  modport slave (
    input  raw1, raw2, raw3, raw4,
    input  Road1, Road2, Road3, Road4,
    output c1, c2, c3, c4,
    output q1, q2, q3, q4
`ifdef DEMAND_OVERFLOW_EN
    ,
    output ovf
`endif
  );
endinterface

// File: rtl/traffic_demand_detector.sv
// traffic_demand_detector
//   Front end of the four-road traffic light controller. Each road has an
//   independent lane: 2-flop synchroniser, debounce filter, vehicle queue
//   counter that counts filtered rising edges and discharges one vehicle per
//   SERVICE_CYCLES green cycles, and a registered demand line.
//   Optional feature macro: DEMAND_OVERFLOW_EN (sticky per-road overflow flags).
// Ports
//   clk    in  system clock, posedge
//   clear  in  synchronous active-high reset of every register
//   bus    slave modport of traffic_demand_if:
//          raw1..4 in, Road1..4 in, c1..4 out, q1..4 out, ovf out (macro only)
module traffic_demand_detector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int QUEUE_MAX       = 15,
  parameter int QUEUE_W         = 4,
  parameter int SERVICE_CYCLES  = 8
) (
  input  logic             clk,
  input  logic             clear,
  traffic_demand_if.slave  bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
  localparam logic [DW-1:0]      DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0]      SVC_LAST = SW'(SERVICE_CYCLES - 1);
  localparam logic [QUEUE_W-1:0] Q_MAX    = QUEUE_W'(QUEUE_MAX);

  // Index 0 is road 1 throughout.
  logic [3:0]               raw;
  logic [3:0][3:0]          road;
  logic [3:0]               s1_q, s1_d, s2_q, s2_d;
  logic [3:0]               filt_q, filt_d, filt_dly_q, filt_dly_d;
  logic [3:0][DW-1:0]       deb_q, deb_d;
  logic [3:0][SW-1:0]       svc_q, svc_d;
  logic [3:0][QUEUE_W-1:0]  q_q, q_d;
  logic [3:0]               c_q, c_d;
  logic [3:0]               arrival, discharge;

  assign raw  = {bus.raw4, bus.raw3, bus.raw2, bus.raw1};
  assign road = {bus.Road4, bus.Road3, bus.Road2, bus.Road1};

  // Saturating queue step; an arrival and a discharge on the same cycle cancel.
  function automatic logic [QUEUE_W-1:0] queue_next(
    input logic [QUEUE_W-1:0] q,
    input logic               arr,
    input logic               dis
  );
    logic [QUEUE_W-1:0] r;
    r = q;
    if (arr && !dis && q != Q_MAX)
      r = q + 1'b1;
    else if (dis && !arr && q != '0)
      r = q - 1'b1;
    return r;
  endfunction

  always_comb begin
    s1_d       = raw;
    s2_d       = s1_q;
    filt_d     = filt_q;
    filt_dly_d = filt_q;
    deb_d      = '0;
    svc_d      = '0;
    // A vehicle is the cycle after the filtered level has risen.
    arrival    = filt_q & ~filt_dly_q;
    discharge  = '0;
    q_d        = q_q;
    c_d        = c_q;
    for (int n = 0; n < 4; n++) begin
      // Mismatch counter; any agreement between s2 and filt restarts it.
      if (s2_q[n] != filt_q[n]) begin
        if (deb_q[n] == DEB_LAST)
          filt_d[n] = s2_q[n];
        else
          deb_d[n] = deb_q[n] + 1'b1;
      end
      // Only code 1 is green; service progress is lost whenever it stops.
      if (road[n] == 4'd1 && q_q[n] != '0) begin
        if (svc_q[n] == SVC_LAST)
          discharge[n] = 1'b1;
        else
          svc_d[n] = svc_q[n] + 1'b1;
      end
      q_d[n] = queue_next(q_q[n], arrival[n], discharge[n]);
      c_d[n] = (q_d[n] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      s1_q       <= '0;
      s2_q       <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      deb_q      <= '0;
      svc_q      <= '0;
      q_q        <= '0;
      c_q        <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_dly_d;
      deb_q      <= deb_d;
      svc_q      <= svc_d;
      q_q        <= q_d;
      c_q        <= c_d;
    end
  end

  assign bus.c1 = c_q[0];
  assign bus.c2 = c_q[1];
  assign bus.c3 = c_q[2];
  assign bus.c4 = c_q[3];
  assign bus.q1 = q_q[0];
  assign bus.q2 = q_q[1];
  assign bus.q3 = q_q[2];
  assign bus.q4 = q_q[3];

`ifdef DEMAND_OVERFLOW_EN
  logic [3:0] ovf_q, ovf_d;

  // Overflow means a vehicle was dropped: arrival at full queue, nothing leaving.
  always_comb begin
    ovf_d = ovf_q;
    for (int n = 0; n < 4; n++) begin
      if (arrival[n] && !discharge[n] && q_q[n] == Q_MAX)
        ovf_d[n] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear)
      ovf_q <= '0;
    else
      ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_traffic_demand_detector.sv
module tb_traffic_demand_detector;

  localparam int DEB  = 4;
  localparam int QMAX = 15;
  localparam int QW   = 4;
  localparam int SVC  = 8;

  logic clk;
  logic clear;

  traffic_demand_if #(.QUEUE_W(QW)) tdi ();

  traffic_demand_detector #(
    .DEBOUNCE_CYCLES(DEB),
    .QUEUE_MAX      (QMAX),
    .QUEUE_W        (QW),
    .SERVICE_CYCLES (SVC)
  ) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (tdi)
  );

  int n_pass  = 0;
  int n_total = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- access helpers ----------------
  task automatic set_raw(int n, bit v);
    case (n)
      0: tdi.raw1 = v;
      1: tdi.raw2 = v;
      2: tdi.raw3 = v;
      default: tdi.raw4 = v;
    endcase
  endtask

  task automatic set_road(int n, int v);
    case (n)
      0: tdi.Road1 = 4'(v);
      1: tdi.Road2 = 4'(v);
      2: tdi.Road3 = 4'(v);
      default: tdi.Road4 = 4'(v);
    endcase
  endtask

  function automatic bit get_raw(int n);
    case (n)
      0: return tdi.raw1;
      1: return tdi.raw2;
      2: return tdi.raw3;
      default: return tdi.raw4;
    endcase
  endfunction

  function automatic int get_road(int n);
    case (n)
      0: return int'(tdi.Road1);
      1: return int'(tdi.Road2);
      2: return int'(tdi.Road3);
      default: return int'(tdi.Road4);
    endcase
  endfunction

  function automatic int get_q(int n);
    case (n)
      0: return int'(tdi.q1);
      1: return int'(tdi.q2);
      2: return int'(tdi.q3);
      default: return int'(tdi.q4);
    endcase
  endfunction

  function automatic int get_c(int n);
    case (n)
      0: return int'(tdi.c1);
      1: return int'(tdi.c2);
      2: return int'(tdi.c3);
      default: return int'(tdi.c4);
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // Each lane remembers the last two raw samples and the last DEB
  // synchronised samples; the filtered level flips once DEB consecutive
  // synchronised samples all disagree with it. A flip upward counts as a
  // vehicle one cycle later. Service counts consecutive green cycles with
  // a non-empty queue.
  bit m_rawh [4][$];
  bit m_s2h  [4][$];
  bit m_filt [4];
  bit m_rose [4];
  bit m_ovf  [4];
  int m_q    [4];
  int m_prog [4];

  function automatic void model_step();
    for (int n = 0; n < 4; n++) begin
      bit s2, arr, dis, run;
      if (clear) begin
        m_rawh[n].delete();
        m_s2h[n].delete();
        m_filt[n] = 1'b0;
        m_rose[n] = 1'b0;
        m_ovf[n]  = 1'b0;
        m_q[n]    = 0;
        m_prog[n] = 0;
      end else begin
        s2 = (m_rawh[n].size() >= 2) ? m_rawh[n][m_rawh[n].size() - 2] : 1'b0;
        m_rawh[n].push_back(get_raw(n));
        if (m_rawh[n].size() > 2) void'(m_rawh[n].pop_front());

        arr = m_rose[n];
        m_rose[n] = 1'b0;
        m_s2h[n].push_back(s2);
        if (m_s2h[n].size() > DEB) void'(m_s2h[n].pop_front());
        run = (m_s2h[n].size() == DEB);
        for (int i = 0; i < m_s2h[n].size(); i++)
          if (m_s2h[n][i] == m_filt[n]) run = 1'b0;
        if (run) begin
          m_rose[n] = !m_filt[n];
          m_filt[n] = !m_filt[n];
          m_s2h[n].delete();
        end

        dis = 1'b0;
        if (get_road(n) == 1 && m_q[n] != 0) begin
          m_prog[n]++;
          if (m_prog[n] == SVC) begin
            dis = 1'b1;
            m_prog[n] = 0;
          end
        end else begin
          m_prog[n] = 0;
        end

        if (arr && !dis) begin
          if (m_q[n] == QMAX) m_ovf[n] = 1'b1;
          else m_q[n]++;
        end else if (dis && !arr) begin
          m_q[n]--;
        end
      end
    end
  endfunction

  // One clock: model consumes the inputs the DUT is about to sample, then
  // outputs are observed 1 time unit after the edge.
  task automatic tick(int k = 1);
    repeat (k) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic add_vehicles(int n, int k);
    repeat (k) begin
      set_raw(n, 1'b1);
      tick(6);
      set_raw(n, 1'b0);
      tick(6);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int lane;
    int len;
    int exp_q;
    int exp_c;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];
  int   hold [4];

  initial begin
    vecs[0] = '{0, 1, 0, 0};
    vecs[1] = '{0, 3, 0, 0};
    vecs[2] = '{0, 4, 1, 1};
    vecs[3] = '{1, 2, 0, 0};
    vecs[4] = '{1, 6, 1, 1};
    vecs[5] = '{2, 3, 0, 0};
    vecs[6] = '{2, 10, 1, 1};
    vecs[7] = '{3, 4, 1, 1};
    vecs[8] = '{3, 30, 1, 1};

    // T1: reset with all sensors high
    clear = 1'b1;
    for (int n = 0; n < 4; n++) begin
      set_raw(n, 1'b1);
      set_road(n, 0);
    end
    tick(2);
    clear = 1'b0;
    tick();
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("t1_q%0d", n + 1), get_q(n), 0);
      chk($sformatf("t1_c%0d", n + 1), get_c(n), 0);
    end
`ifdef DEMAND_OVERFLOW_EN
    chk("t1_ovf", int'(tdi.ovf), 0);
`endif
    for (int n = 0; n < 4; n++) set_raw(n, 1'b0);
    pulse_clear();

    // Table: pulse width versus counted arrivals
    for (int i = 0; i < NV; i++) begin
      pulse_clear();
      set_raw(vecs[i].lane, 1'b1);
      tick(vecs[i].len);
      set_raw(vecs[i].lane, 1'b0);
      tick(12);
      chk($sformatf("vec%0d_q", i), get_q(vecs[i].lane), vecs[i].exp_q);
      chk($sformatf("vec%0d_c", i), get_c(vecs[i].lane), vecs[i].exp_c);
    end

    // T2: exact arrival latency, edge 6
    pulse_clear();
    set_raw(0, 1'b1);
    tick(6);
    chk("t2_edge5_q1", get_q(0), 0);
    chk("t2_edge5_c1", get_c(0), 0);
    tick();
    chk("t2_edge6_q1", get_q(0), 1);
    chk("t2_edge6_c1", get_c(0), 1);
    set_raw(0, 1'b0);
    tick(8);

    // T3: bouncing sensor gives a single vehicle
    pulse_clear();
    for (int i = 0; i < 20; i++) begin
      set_raw(1, (i % 2) == 0);
      tick();
    end
    set_raw(1, 1'b1);
    tick(12);
    chk("t3_q2", get_q(1), 1);
    chk("t3_c2", get_c(1), 1);
    set_raw(1, 1'b0);
    tick(8);

    // T4: service cadence and interrupted service
    pulse_clear();
    add_vehicles(2, 3);
    chk("t4_q3_init", get_q(2), 3);
    set_road(2, 1);
    tick(7);
    chk("t4_g7_q3", get_q(2), 3);
    tick();
    chk("t4_g8_q3", get_q(2), 2);
    tick(7);
    chk("t4_g15_q3", get_q(2), 2);
    tick();
    chk("t4_g16_q3", get_q(2), 1);
    tick(7);
    chk("t4_g23_c3", get_c(2), 1);
    tick();
    chk("t4_g24_q3", get_q(2), 0);
    chk("t4_g24_c3", get_c(2), 0);
    set_road(2, 0);
    add_vehicles(2, 3);
    set_road(2, 1);
    tick(5);
    set_road(2, 2);
    tick(3);
    chk("t4_yellow_q3", get_q(2), 3);
    set_road(2, 1);
    tick(7);
    chk("t4_restart_g7_q3", get_q(2), 3);
    tick();
    chk("t4_restart_g8_q3", get_q(2), 2);
    set_road(2, 3);
    tick(20);
    chk("t4_code3_q3", get_q(2), 2);
    set_road(2, 0);

    // T5: arrival on the discharge edge, then saturation
    pulse_clear();
    add_vehicles(3, 2);
    chk("t5_q4_init", get_q(3), 2);
    set_road(3, 1);
    tick();
    set_raw(3, 1'b1);
    tick(6);
    chk("t5_g7_q4", get_q(3), 2);
    tick();
    chk("t5_g8_both_q4", get_q(3), 2);
    tick(7);
    chk("t5_g15_q4", get_q(3), 2);
    tick();
    chk("t5_g16_q4", get_q(3), 1);
    set_road(3, 0);
    set_raw(3, 1'b0);
    tick(8);

    pulse_clear();
    add_vehicles(3, 17);
    chk("t5_burst_q4", get_q(3), QMAX);
    chk("t5_burst_c4", get_c(3), 1);
`ifdef DEMAND_OVERFLOW_EN
    chk("t5_burst_ovf", int'(tdi.ovf), 8);
`endif
    set_road(3, 1);
    tick(QMAX * SVC + 4);
    chk("t5_drain_q4", get_q(3), 0);
    chk("t5_drain_c4", get_c(3), 0);
`ifdef DEMAND_OVERFLOW_EN
    chk("t5_drain_ovf", int'(tdi.ovf), 8);
`endif
    set_road(3, 0);

    // T6: clear in the middle of service and debounce
    pulse_clear();
`ifdef DEMAND_OVERFLOW_EN
    chk("t6_ovf_cleared", int'(tdi.ovf), 0);
`endif
    add_vehicles(0, 5);
    chk("t6_q1_init", get_q(0), 5);
    set_road(0, 1);
    set_raw(1, 1'b1);
    tick(3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clr_q1", get_q(0), 0);
    chk("t6_clr_c1", get_c(0), 0);
    chk("t6_clr_q2", get_q(1), 0);
    tick(6);
    chk("t6_edge5_q2", get_q(1), 0);
    tick();
    chk("t6_edge6_q2", get_q(1), 1);
    chk("t6_edge6_q1", get_q(0), 0);
    set_raw(1, 1'b0);
    set_road(0, 0);
    tick(8);

    // Randomised traffic against the reference model
    pulse_clear();
    for (int n = 0; n < 4; n++) hold[n] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 4; n++) begin
        int r;
        if (hold[n] == 0) begin
          set_raw(n, $urandom_range(0, 1) == 1);
          hold[n] = $urandom_range(1, 9);
        end
        hold[n]--;
        if ($urandom_range(0, 15) == 0) begin
          r = $urandom_range(0, 9);
          if (r < 4)      set_road(n, 1);
          else if (r < 7) set_road(n, 0);
          else if (r < 9) set_road(n, 2);
          else            set_road(n, $urandom_range(3, 15));
        end
      end
      clear = ($urandom_range(0, 699) == 0);
      tick();
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("rnd_q%0d", n + 1), get_q(n), m_q[n]);
        chk($sformatf("rnd_c%0d", n + 1), get_c(n), (m_q[n] != 0) ? 1 : 0);
      end
`ifdef DEMAND_OVERFLOW_EN
      chk("rnd_ovf", int'(tdi.ovf),
          int'(m_ovf[0]) | (int'(m_ovf[1]) << 1) | (int'(m_ovf[2]) << 2) | (int'(m_ovf[3]) << 3));
`endif
    end
    clear = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
